// File: rtl/rgb_kernel3x3_filter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rgb_kernel3x3_filter: 3-stage 3x3 RGB kernel filter (box/Gaussian/sharpen/bypass)
// Optional feature macro: KERNEL_SHARPEN_EN.                         Rev 1.0
// -----------------------------------------------------------------------------
module rgb_kernel3x3_filter #(
  parameter  int CW  = 4,
  parameter  int NCH = 3,
  localparam int PW  = CW * NCH
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [9*PW-1:0] window_data,
  input  logic [1:0]      mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PW-1:0]   filter_out,
  output logic [PW-1:0]   center_out
);

  localparam logic [1:0] MODE_BOX   = 2'd0;
  localparam logic [1:0] MODE_GAUSS = 2'd1;
`ifdef KERNEL_SHARPEN_EN
  localparam logic [1:0] MODE_SHARP = 2'd2;
`endif

  // Wide enough to hold the box product S*57+256 without overflow.
  localparam int XW = CW + 11;
  localparam logic [XW-1:0]   MAX_X   = XW'((64'd1 << CW) - 64'd1);
  localparam logic [XW-1:0]   BOX_MUL = XW'(57);
  localparam logic [XW-1:0]   BOX_RND = XW'(256);
  localparam logic [CW+4:0]   GAU_RND = (CW+5)'(8);

  function automatic logic [CW-1:0] sat(input logic [XW-1:0] v);
    return (v > MAX_X) ? MAX_X[CW-1:0] : v[CW-1:0];
  endfunction

  logic            adv;
  logic            s1_valid;
  logic [1:0]      s1_mode;
  logic [9*PW-1:0] s1_win;
  logic            s2_valid;
  logic [1:0]      s2_mode;
  logic [PW-1:0]   s2_center;
  logic [PW-1:0]   res_pix;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_mode    <= 2'd0;
      s1_win     <= '0;
      s2_valid   <= 1'b0;
      s2_mode    <= 2'd0;
      s2_center  <= '0;
      out_valid  <= 1'b0;
      filter_out <= '0;
      center_out <= '0;
    end else if (adv) begin
      s1_valid   <= in_valid;
      s1_mode    <= mode;
      s1_win     <= window_data;
      s2_valid   <= s1_valid;
      s2_mode    <= s1_mode;
      s2_center  <= s1_win[9*PW-1 -: PW];
      out_valid  <= s2_valid;
      filter_out <= res_pix;
      center_out <= s2_center;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    // px[8] is the centre; 7..4 are the edge neighbours, 3..0 the corners.
    logic [CW-1:0] px [9];
    logic [CW+1:0] e_sum, k_sum;
    logic [CW-1:0] c_q;
    logic [CW+1:0] e_q, k_q;
    logic [CW+3:0] box_sum;
    logic [XW-1:0] box_prod, box_shr;
    logic [CW+4:0] gau_sum;
    logic [XW-1:0] gau_shr;
    logic [CW-1:0] res;

    for (genvar j = 0; j < 9; j++) begin : g_px
      assign px[j] = s1_win[j*PW + ch*CW +: CW];
    end

    assign e_sum = {2'b00, px[7]} + {2'b00, px[6]} + {2'b00, px[5]} + {2'b00, px[4]};
    assign k_sum = {2'b00, px[3]} + {2'b00, px[2]} + {2'b00, px[1]} + {2'b00, px[0]};

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        c_q <= '0;
        e_q <= '0;
        k_q <= '0;
      end else if (adv) begin
        c_q <= px[8];
        e_q <= e_sum;
        k_q <= k_sum;
      end
    end

    assign box_sum  = {4'b0000, c_q} + {2'b00, e_q} + {2'b00, k_q};
    assign box_prod = {7'b0000000, box_sum} * BOX_MUL + BOX_RND;
    assign box_shr  = box_prod >> 9;
    assign gau_sum  = {3'b000, c_q, 2'b00} + {2'b00, e_q, 1'b0} + {3'b000, k_q} + GAU_RND;
    assign gau_shr  = {6'b000000, gau_sum} >> 4;

`ifdef KERNEL_SHARPEN_EN
    logic signed [CW+3:0] c_s, e_s, sh;
    assign c_s = signed'({4'b0000, c_q});
    assign e_s = signed'({2'b00, e_q});
    assign sh  = (c_s <<< 2) + c_s - e_s;
`endif

    always_comb begin
      res = c_q;
      case (s2_mode)
        MODE_BOX:   res = sat(box_shr);
        MODE_GAUSS: res = sat(gau_shr);
`ifdef KERNEL_SHARPEN_EN
        MODE_SHARP: res = sh[CW+3] ? '0 : sat({7'b0000000, sh});
`endif
        default:    res = c_q;
      endcase
    end

    assign res_pix[ch*CW +: CW] = res;
  end

endmodule
`default_nettype wire
